// File: rtl/usb_packet_transmitter.sv
// usb_packet_transmitter: device-side USB full-speed packet serializer.
// Accepts a byte stream (PID first) over valid/ready and drives SYNC,
// NRZI-encoded bit-stuffed data (LSB first) and EOP onto the D+/D- pads.
module usb_packet_transmitter #(
  parameter int          CLOCKS_PER_BIT = 4,
  parameter logic [7:0]  SYNC_PATTERN   = 8'b01010100,
  parameter int          STUFF_LIMIT    = 6
) (
  input  logic       clock48,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       usb_dp_out,
  output logic       usb_dn_out,
  output logic       usb_oe
);

  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [OW-1:0] ONES_LIMIT = OW'(STUFF_LIMIT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STUFF   = 3'd3;
  localparam logic [2:0] S_EOP_SE0 = 3'd4;
  localparam logic [2:0] S_EOP_J   = 3'd5;

  // Current-bit registers: state, bit-time counter, index within field,
  // data shift register (bit 0 is the bit on the line), NRZI level and
  // the run of consecutive decoded ones including the current bit.
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_last;
  logic          r_level;
  logic [OW-1:0] r_ones;
  logic          r_busy;
  logic          r_dp;
  logic          r_dn;
  logic          r_underrun;

  logic          w_bit_end;
  logic          w_stuff_due;
  logic          w_byte_end;
  logic          w_ready;

  logic [2:0]    w_state_n;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    w_idx_n;
  logic [7:0]    w_shift_n;
  logic          w_last_n;
  logic          w_level_n;
  logic [OW-1:0] w_ones_n;
  logic          w_underrun_n;
  logic          w_enter;
  logic          w_advance;
  logic          w_new_byte;
  logic          w_bit;
  logic          w_base_lvl;
  logic [OW-1:0] w_base_ones;
  logic          w_busy_n;
  logic          w_dp_n;
  logic          w_dn_n;

  // Bit-boundary and byte-boundary decode.
  always_comb begin
    w_bit_end   = (r_cnt == BIT_LAST);
    w_stuff_due = (r_ones == ONES_LIMIT);
    w_byte_end  = w_bit_end && (r_idx == 3'd7) &&
                  (((r_state == S_DATA) && !w_stuff_due) || (r_state == S_STUFF));
    w_ready     = reset_n && (((r_state == S_IDLE) && tx_valid) ||
                              (w_byte_end && !r_last));
  end

  // Next-state logic for the serializer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_shift_n    = r_shift;
    w_last_n     = r_last;
    w_level_n    = r_level;
    w_ones_n     = r_ones;
    w_underrun_n = 1'b0;
    w_enter      = 1'b0;
    w_advance    = 1'b0;
    w_new_byte   = 1'b0;
    w_bit        = 1'b0;
    w_base_lvl   = r_level;
    w_base_ones  = r_ones;
    w_cnt_n      = (r_state == S_IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_state_n = S_SYNC;
          w_idx_n   = 3'd0;
          w_shift_n = tx_data;
          w_last_n  = tx_last;
        end
      end
      S_SYNC: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) w_enter = 1'b1;
          else               w_idx_n = r_idx + 3'd1;
        end
      end
      S_DATA, S_STUFF: begin
        if (w_bit_end) begin
          if ((r_state == S_DATA) && w_stuff_due) begin
            w_state_n = S_STUFF;
            w_level_n = ~r_level;
            w_ones_n  = '0;
          end else if (r_idx == 3'd7) begin
            if (!r_last && tx_valid) begin
              w_enter    = 1'b1;
              w_new_byte = 1'b1;
            end else begin
              w_underrun_n = !r_last;
              w_state_n    = S_EOP_SE0;
              w_idx_n      = 3'd0;
            end
          end else begin
            w_enter   = 1'b1;
            w_advance = 1'b1;
          end
        end
      end
      S_EOP_SE0: begin
        if (w_bit_end) begin
          if (r_idx == 3'd1) w_state_n = S_EOP_J;
          else               w_idx_n   = r_idx + 3'd1;
        end
      end
      default: begin
        if (w_bit_end || r_state != S_EOP_J) w_state_n = S_IDLE;
      end
    endcase

    // Start of a new data bit: pick its value and NRZI-encode it.
    if (w_enter) begin
      if (w_new_byte) begin
        w_bit     = tx_data[0];
        w_shift_n = tx_data;
        w_last_n  = tx_last;
        w_idx_n   = 3'd0;
      end else if (w_advance) begin
        w_bit     = r_shift[1];
        w_shift_n = r_shift >> 1;
        w_idx_n   = r_idx + 3'd1;
      end else begin
        w_bit   = r_shift[0];
        w_idx_n = 3'd0;
      end
      // SYNC ends on K after a K-K pair, i.e. one decoded one.
      if (r_state == S_SYNC) begin
        w_base_lvl  = 1'b0;
        w_base_ones = OW'(1);
      end
      w_state_n = S_DATA;
      w_level_n = w_bit ? w_base_lvl : ~w_base_lvl;
      w_ones_n  = w_bit ? w_base_ones + OW'(1) : '0;
    end
  end

  // Pad values for the next bit, registered so the pads only move on a
  // bit boundary and never glitch.
  always_comb begin
    w_busy_n = 1'b1;
    w_dp_n   = 1'b1;
    w_dn_n   = 1'b0;
    case (w_state_n)
      S_IDLE:    w_busy_n = 1'b0;
      S_SYNC: begin
        w_dp_n = SYNC_PATTERN[3'd7 - w_idx_n];
        w_dn_n = ~w_dp_n;
      end
      S_DATA, S_STUFF: begin
        w_dp_n = w_level_n;
        w_dn_n = ~w_level_n;
      end
      S_EOP_SE0: begin
        w_dp_n = 1'b0;
        w_dn_n = 1'b0;
      end
      default: ;
    endcase
  end

  // State and pad registers; reset drops the pads to idle J at once.
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_shift    <= 8'd0;
      r_last     <= 1'b0;
      r_level    <= 1'b0;
      r_ones     <= '0;
      r_busy     <= 1'b0;
      r_dp       <= 1'b1;
      r_dn       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_idx      <= w_idx_n;
      r_shift    <= w_shift_n;
      r_last     <= w_last_n;
      r_level    <= w_level_n;
      r_ones     <= w_ones_n;
      r_busy     <= w_busy_n;
      r_dp       <= w_dp_n;
      r_dn       <= w_dn_n;
      r_underrun <= w_underrun_n;
    end
  end

  assign tx_ready    = w_ready;
  assign tx_busy     = r_busy;
  assign usb_oe      = r_busy;
  assign usb_dp_out  = r_dp;
  assign usb_dn_out  = r_dn;
  assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_usb_packet_transmitter.sv
// tb_usb_packet_transmitter: directed bench for the USB packet serializer.
// Accepted bytes go into a scoreboard; an NRZI/destuff decoder recovers
// bytes from the logged pad values and pops the scoreboard.
module tb_usb_packet_transmitter;

  localparam int CPB = 4;

  logic       clock48;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_underrun;
  logic       usb_dp_out;
  logic       usb_dn_out;
  logic       usb_oe;

  int         n_assert;
  int         n_fail;
  logic       q_dp[$];
  logic       q_dn[$];
  logic       q_oe[$];
  logic [7:0] sb[$];
  int         n_ready;
  int         n_underrun;
  logic [63:0] dp_bits;
  logic [7:0]  sync_pat;

  usb_packet_transmitter dut (
    .clock48     (clock48),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_underrun (tx_underrun),
    .usb_dp_out  (usb_dp_out),
    .usb_dn_out  (usb_dn_out),
    .usb_oe      (usb_oe)
  );

  initial begin
    clock48 = 1'b0;
    forever #5 clock48 = ~clock48;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive n bytes (byte i = bytes[8*i +: 8]) and log pads until the packet ends.
  task automatic run_packet(input logic [31:0] bytes, input int n, input bit underrun);
    int idx  = 0;
    bit seen = 0;
    bit done = 0;
    bit hs;
    q_dp.delete(); q_dn.delete(); q_oe.delete();
    n_ready = 0; n_underrun = 0;
    @(posedge clock48); #1;
    tx_valid = 1'b1;
    tx_data  = bytes[7:0];
    tx_last  = (n == 1) && !underrun;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clock48);
      q_dp.push_back(usb_dp_out);
      q_dn.push_back(usb_dn_out);
      q_oe.push_back(usb_oe);
      if (tx_ready)    n_ready++;
      if (tx_underrun) n_underrun++;
      if (usb_oe) seen = 1;
      else if (seen) done = 1;
      hs = tx_ready && tx_valid;
      @(posedge clock48); #1;
      if (hs) begin
        sb.push_back(tx_data);
        idx++;
        if (idx < n) begin
          tx_data = bytes[8*idx +: 8];
          tx_last = (idx == n - 1) && !underrun;
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
          tx_data  = 8'h00;
        end
      end
    end
    check("packet_done", 64'(done), 64'd1);
  endtask

  // Decode the logged line: SYNC, NRZI/destuff into bytes, then EOP.
  task automatic decode(input string tag, input int exp_dbits, output logic [63:0] bits);
    int s = -1, len = 0, nb, k, base, nbit = 0, dbits = 0, ones = 1;
    int glitch = 0, sync_err = 0, line_err = 0;
    logic prev = 1'b0, dp, dn, bitv;
    logic [7:0] acc = 8'h00, exp_b;
    logic [3:0] eop;
    bits = '0;
    for (int i = 0; i < q_oe.size(); i++) begin
      if (q_oe[i] && s < 0) s = i;
      if (s >= 0 && i >= s && q_oe[i] && len == i - s) len++;
    end
    check({tag, "_oe_len"}, 64'(len), 64'(CPB * (8 + exp_dbits + 3)));
    if (s < 0) s = 0;
    nb = len / CPB;
    for (k = 0; k < nb; k++) begin
      base = s + k * CPB;
      for (int j = 1; j < CPB; j++)
        if (q_dp[base+j] !== q_dp[base] || q_dn[base+j] !== q_dn[base]) glitch++;
      if (k < 64) bits[k] = q_dp[base + CPB/2];
    end
    check({tag, "_bit_width"}, 64'(glitch), 64'd0);
    for (k = 0; k < 8 && k < nb; k++) begin
      dp = q_dp[s + k*CPB + CPB/2];
      dn = q_dn[s + k*CPB + CPB/2];
      if (dp !== sync_pat[7-k] || dn !== ~dp) sync_err++;
    end
    check({tag, "_sync"}, 64'(sync_err), 64'd0);
    k = 8;
    while (k < nb) begin
      dp = q_dp[s + k*CPB + CPB/2];
      dn = q_dn[s + k*CPB + CPB/2];
      if (dp == 1'b0 && dn == 1'b0) break;
      if (dn !== ~dp) line_err++;
      bitv = (dp == prev);
      prev = dp;
      dbits++;
      k++;
      if (ones == 6) begin
        if (bitv != 1'b0) line_err++;
        ones = 0;
      end else begin
        ones = bitv ? ones + 1 : 0;
        acc[nbit] = bitv;
        nbit++;
        if (nbit == 8) begin
          exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
          check({tag, "_byte"}, 64'(acc), 64'(exp_b));
          nbit = 0;
        end
      end
    end
    check({tag, "_data_bits"}, 64'(dbits), 64'(exp_dbits));
    check({tag, "_line"}, 64'(line_err + nbit), 64'd0);
    eop = 4'b0000;
    if (k + 3 <= nb) begin
      eop[3] = (q_dp[s + k*CPB + CPB/2] === 1'b0) && (q_dn[s + k*CPB + CPB/2] === 1'b0);
      eop[2] = (q_dp[s + (k+1)*CPB + CPB/2] === 1'b0) && (q_dn[s + (k+1)*CPB + CPB/2] === 1'b0);
      eop[1] = (q_dp[s + (k+2)*CPB + CPB/2] === 1'b1) && (q_dn[s + (k+2)*CPB + CPB/2] === 1'b0);
      eop[0] = (k + 3 == nb);
    end
    check({tag, "_eop"}, 64'(eop), 64'hF);
    check({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    sync_pat = 8'b01010100;
    reset_n  = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    tx_last  = 1'b0;

    // Reset state, with tx_valid high to show tx_ready is held low.
    #23;
    check("rst_ready",    64'(tx_ready),    64'd0);
    check("rst_oe",       64'(usb_oe),      64'd0);
    check("rst_pads",     64'({usb_dp_out, usb_dn_out}), 64'b10);
    check("rst_busy",     64'(tx_busy),     64'd0);
    check("rst_underrun", 64'(tx_underrun), 64'd0);
    tx_valid = 1'b0;
    @(negedge clock48);
    reset_n = 1'b1;
    repeat (3) @(posedge clock48);

    // ACK: single PID byte 0xD2.
    run_packet(32'h0000_00D2, 1, 1'b0);
    decode("ack", 8, dp_bits);
    check("ack_dp_seq",  64'(dp_bits[18:0]), 64'(19'b1000001101100101010));
    check("ack_ready",   64'(n_ready),    64'd1);
    check("ack_underrun",64'(n_underrun), 64'd0);
    repeat (4) @(posedge clock48);

    // Stuffing across a byte boundary: C3 then FF.
    run_packet(32'h0000_FFC3, 2, 1'b0);
    decode("stuff", 17, dp_bits);
    check("stuff_ready", 64'(n_ready), 64'd2);
    repeat (4) @(posedge clock48);

    // Stuff bit after bit 7 of the last byte.
    run_packet(32'h0000_00FC, 1, 1'b0);
    decode("trail", 9, dp_bits);
    repeat (4) @(posedge clock48);

    // Back-to-back bytes with tx_valid held high.
    run_packet(32'h0302_014B, 4, 1'b0);
    decode("b2b", 32, dp_bits);
    check("b2b_ready", 64'(n_ready), 64'd4);
    repeat (4) @(posedge clock48);

    // Underrun: byte without last, then nothing offered.
    run_packet(32'h0000_00C3, 1, 1'b1);
    decode("undr", 8, dp_bits);
    check("undr_pulse", 64'(n_underrun), 64'd1);
    check("undr_ready", 64'(n_ready),    64'd2);
    check("undr_idle",  64'({tx_busy, usb_oe}), 64'd0);
    repeat (4) @(posedge clock48);

    // Reset in the middle of DATA.
    @(posedge clock48); #1;
    tx_valid = 1'b1; tx_data = 8'hD2; tx_last = 1'b1;
    @(posedge clock48); #1;
    tx_valid = 1'b0; tx_last = 1'b0;
    repeat (45) @(posedge clock48);
    #1;
    check("mid_busy_before", 64'(tx_busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_oe",   64'(usb_oe),  64'd0);
    check("mid_pads", 64'({usb_dp_out, usb_dn_out}), 64'b10);
    check("mid_busy", 64'(tx_busy), 64'd0);
    @(negedge clock48);
    reset_n = 1'b1;
    repeat (3) @(posedge clock48);
    run_packet(32'h0000_00D2, 1, 1'b0);
    decode("post", 8, dp_bits);
    check("post_dp_seq", 64'(dp_bits[18:0]), 64'(19'b1000001101100101010));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_packet_transmitter.md
Name: usb_packet_transmitter

Overview:
- Device-side USB full-speed packet serializer; the transmit counterpart of the host packet driver used in the USB bench.
- Takes a byte stream from the USB protocol engine, PID byte first, over a valid/ready handshake.
- Emits SYNC, NRZI-encoded bit-stuffed data (LSB first) and EOP on the D+/D- pads. Drives output enable only while transmitting.
- Sits between the USB device controller and the pad tristate logic in top.

Parameters:
CLOCKS_PER_BIT, 4, clock48 cycles per full-speed bit time (48 MHz / 12 MHz).
SYNC_PATTERN, 8'b01010100, D+ levels of the SYNC field, sent MSB first.
STUFF_LIMIT, 6, run of decoded ones that forces a stuffed zero.

Ports:
clock48  input  1  48 MHz system clock.
reset_n  input  1  Asynchronous, active-low reset.
tx_data  input  8  Byte to transmit.
tx_valid  input  1  tx_data/tx_last are valid.
tx_last  input  1  Current byte is the final byte of the packet.
tx_ready  output  1  Byte is consumed this cycle if tx_valid is high.
tx_busy  output  1  Packet in progress, from SYNC start through the end of the EOP J bit.
tx_underrun  output  1  One-cycle pulse when a packet is aborted because no byte was available.
usb_dp_out  output  1  D+ drive value.
usb_dn_out  output  1  D- drive value.
usb_oe  output  1  Pad output enable.

Behaviour:
- Reset, async while reset_n=0: state IDLE, usb_oe=0, usb_dp_out=1, usb_dn_out=0 (J), tx_ready=0, tx_busy=0, tx_underrun=0. Reset mid-packet aborts immediately with no EOP.
- Bit timer:
  - Counter runs 0..CLOCKS_PER_BIT-1 while tx_busy is high.
  - Pad values change only on the cycle after the counter wraps, so every bit lasts exactly CLOCKS_PER_BIT cycles.
  - Counter is held at 0 in IDLE.
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE:
  - tx_ready = tx_valid, combinational: the first byte is accepted on the same edge the packet starts.
  - On valid&ready: load the shift register, latch tx_last, go to SYNC.
  - usb_oe, tx_busy and the first SYNC bit appear on the next cycle.
- SYNC:
  - 8 bit times. D+ = SYNC_PATTERN[7-i], D- = ~D+ (K J K J K J K K).
  - On exit: NRZI level = 0 (K), ones counter = 1.
- DATA:
  - Bits are sent LSB first.
  - Bit 0 toggles the line level; bit 1 holds it.
  - A decoded 1 increments the ones counter; a decoded 0 clears it.
- STUFF:
  - Entered after any data bit that brings the ones counter to STUFF_LIMIT, including bit 7 of any byte and bit 7 of the last byte.
  - Sends one toggle bit, then clears the counter.
- Byte boundary (final cycle of bit 7, or of its trailing stuff bit):
  - If the latched last=0: tx_ready=1 for that single cycle.
    - tx_valid=1: load the next byte; its bit 0 follows with no gap.
    - tx_valid=0: underrun. Pulse tx_underrun, go to EOP_SE0.
  - If latched last=1: go to EOP_SE0; tx_ready stays 0.
- tx_ready is never high in SYNC or EOP states, nor mid-byte.
- EOP_SE0: 2 bit times, D+=D-=0.
- EOP_J: 1 bit time, D+=1, D-=0. Then IDLE: usb_oe=0 and tx_busy=0 on the same cycle.
- A new packet can be accepted in the first IDLE cycle. Inter-packet gap is the caller's responsibility.
- Counters are sized so no wrap is possible; packet length is unlimited.

Test Plan:
- ACK packet, single byte 0xD2 with last=1 -> usb_oe high for exactly 76 cycles.
  - D+ per bit: SYNC 0,1,0,1,0,1,0,0; data 1,1,0,1,1,0,0,0; SE0, SE0, J.
  - tx_ready high exactly once (the accept cycle).
- Stuffing: bytes 0xC3, then 0xFF with last=1.
  - The 0xFF run is counted from the preceding ones.
  - A toggle bit is inserted after each 6th consecutive one.
  - Bench NRZI/destuff decoder recovers C3 FF exactly.
- Trailing stuff: last byte 0xFC -> stuffed bit precedes SE0; total data bit times = 9.
- Back-to-back: 0x4B, 0x01, 0x02, 0x03 (last) with tx_valid held high -> tx_ready pulses 4 times.
  - No idle bit between bytes; 3 SE0/J bits follow.
- Underrun: 0xC3 (last=0), then tx_valid low at the boundary -> tx_underrun pulses once; SE0, SE0, J follow; then IDLE.
- Reset mid-DATA: reset_n low -> usb_oe=0, D+=1, D-=0, tx_busy=0 in the same cycle.
  - After release, a new 0xD2 packet is transmitted correctly.
